// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM read arbiter: requester IDs,
// round-robin pointer encoding and the read tag carried alongside each RAM read.
package ram_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID0 = 1'b0;
  localparam req_id_t REQ_ID1 = 1'b1;

  // Forwarded data is held at this width; instances must use DATA_W <= TAG_DATA_W.
  localparam int TAG_DATA_W = 64;

  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } rr_ptr_t;

  typedef struct packed {
    logic                  valid;
    req_id_t               id;
    logic                  fwd;
    logic [TAG_DATA_W-1:0] fwd_data;
  } tag_t;

endpackage

// File: rtl/ram_rd_arbiter_rr_arb2.sv
// 2-way round-robin arbiter: combinational grants, 1-bit pointer that moves to
// the non-granted requester after every issue. Grants are held low in reset.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic    clka,
  input  logic    rst_n,
  input  logic    req0,
  input  logic    req1,
  output logic    gnt0,
  output logic    gnt1,
  output rr_ptr_t ptr
);

  rr_ptr_t ptr_q;
  rr_ptr_t ptr_d;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_REQ0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (rst_n) begin
      if (req0 && (!req1 || ptr_q == PTR_REQ0)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      ptr_d = PTR_REQ1;
    end else if (gnt1) begin
      ptr_d = PTR_REQ0;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_rd_arbiter.sv
// Two-requester read arbiter in front of a simple dual-port RAM with RD_LAT
// read latency. Optional write-to-read forwarding: RAM_RD_ARB_WR_FWD_EN.
module ram_rd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 2
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  output logic              regceb,
  output logic              rstb,
  input  logic [DATA_W-1:0] doutb,
  output logic              rr_ptr
);

  rr_ptr_t ptr;
  tag_t    new_tag;
  tag_t    tag_q [RD_LAT];
  tag_t    tag_out;

  rr_arb2 u_rr_arb2 (
    .clka  (clka),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .ptr   (ptr)
  );

  assign rr_ptr = ptr;

  assign wea   = wr_en;
  assign addra = wr_addr;
  assign dina  = wr_data;

  assign enb    = (gnt0 & req0) | (gnt1 & req1);
  assign regceb = (RD_LAT == 2);
  assign rstb   = 1'b0;

  always_comb begin
    addrb = '0;
    if (gnt0 && req0) begin
      addrb = addr0;
    end else if (gnt1 && req1) begin
      addrb = addr1;
    end
  end

  always_comb begin
    new_tag       = '0;
    new_tag.valid = enb;
    new_tag.id    = gnt1 ? REQ_ID1 : REQ_ID0;
`ifdef RAM_RD_ARB_WR_FWD_EN
    // The RAM returns old data on a same-edge collision, so capture the write here.
    new_tag.fwd      = enb && wr_en && (wr_addr == addrb);
    new_tag.fwd_data = TAG_DATA_W'(wr_data);
`else
    // Forwarding fields stay constant zero, so no forwarding state is kept.
    new_tag.fwd      = 1'b0;
    new_tag.fwd_data = '0;
`endif
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[RD_LAT-1];
  assign rvalid0 = tag_out.valid && (tag_out.id == REQ_ID0);
  assign rvalid1 = tag_out.valid && (tag_out.id == REQ_ID1);
  assign rdata   = tag_out.fwd ? DATA_W'(tag_out.fwd_data) : doutb;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Scoreboard bench: one RD_LAT=2 and one RD_LAT=1 arbiter share stimulus, each
// backed by its own RAM model; a reference model predicts grants and read data.
module tb_ram_rd_arbiter;

  localparam int AW = 9;
  localparam int DW = 64;
  localparam int EW = 1 + 32 + DW;

  // clock / reset
  logic clka = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  // shared stimulus
  logic          req0 = 1'b0, req1 = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  // index 0: RD_LAT=2 instance, index 1: RD_LAT=1 instance
  logic          gnt0 [2], gnt1 [2], rvalid0 [2], rvalid1 [2];
  logic          wea [2], enb [2], regceb [2], rstb [2], rr_ptr [2];
  logic [AW-1:0] addra [2], addrb [2];
  logic [DW-1:0] rdata [2], dina [2], doutb [2];

  ram_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut_lat2 (
    .clka(clka), .rst_n(rst_n), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .rdata(rdata[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wea(wea[0]), .addra(addra[0]), .dina(dina[0]), .enb(enb[0]), .addrb(addrb[0]),
    .regceb(regceb[0]), .rstb(rstb[0]), .doutb(doutb[0]), .rr_ptr(rr_ptr[0])
  );

  ram_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_lat1 (
    .clka(clka), .rst_n(rst_n), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .rdata(rdata[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wea(wea[1]), .addra(addra[1]), .dina(dina[1]), .enb(enb[1]), .addrb(addrb[1]),
    .regceb(regceb[1]), .rstb(rstb[1]), .doutb(doutb[1]), .rr_ptr(rr_ptr[1])
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return {32'hC0DE_0000 + 32'(i), ~32'(i * 3)};
  endfunction

  // RAM models: read-first on a collision, optional output register
  for (genvar k = 0; k < 2; k++) begin : g_ram
    localparam int LAT = (k == 0) ? 2 : 1;
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] q1;

    initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    end

    always @(posedge clka) begin
      if (enb[k]) q1 <= mem[addrb[k]];
      if (wea[k]) mem[addra[k]] <= dina[k];
    end

    if (LAT == 2) begin : g_oreg
      logic [DW-1:0] q2;
      always @(posedge clka) if (regceb[k]) q2 <= rstb[k] ? '0 : q1;
      assign doutb[k] = q2;
    end else begin : g_noreg
      assign doutb[k] = q1;
    end
  end

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [1 << AW];
  int            prefer = 0;
  logic [EW-1:0] exp_q0 [$];
  logic [EW-1:0] exp_q1 [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver: one cycle of stimulus, grant check, expected-response push
  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic r1,
                       input logic [AW-1:0] a1, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
    int            g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clka);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    g = -1;
    if (r0 && r1) g = prefer;
    else if (r0) g = 0;
    else if (r1) g = 1;
    ea = (g == 0) ? a0 : (g == 1) ? a1 : '0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt0 dut%0d cyc%0d", k, cyc), DW'(gnt0[k]), DW'(g == 0));
      chk($sformatf("gnt1 dut%0d cyc%0d", k, cyc), DW'(gnt1[k]), DW'(g == 1));
      chk($sformatf("enb dut%0d cyc%0d", k, cyc), DW'(enb[k]), DW'(g >= 0));
      chk($sformatf("addrb dut%0d cyc%0d", k, cyc), DW'(addrb[k]), DW'(ea));
      chk($sformatf("wea dut%0d cyc%0d", k, cyc), DW'(wea[k]), DW'(we));
      if (we) begin
        chk($sformatf("addra dut%0d cyc%0d", k, cyc), DW'(addra[k]), DW'(wa));
        chk($sformatf("dina dut%0d cyc%0d", k, cyc), dina[k], wd);
      end
    end
    if (g >= 0) begin
      ed = ref_mem[ea];
`ifdef RAM_RD_ARB_WR_FWD_EN
      if (we && wa == ea) ed = wd;
`endif
      exp_q0.push_back({1'(g), 32'(cyc + 2), ed});
      exp_q1.push_back({1'(g), 32'(cyc + 1), ed});
      prefer = 1 - g;
    end
    if (we) ref_mem[wa] = wd;
  endtask

  task automatic do_reset();
    @(negedge clka);
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; wr_en = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    prefer = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_gnt0 dut%0d", k), DW'(gnt0[k]), '0);
      chk($sformatf("rst_gnt1 dut%0d", k), DW'(gnt1[k]), '0);
      chk($sformatf("rst_enb dut%0d", k), DW'(enb[k]), '0);
      chk($sformatf("rst_rvalid dut%0d", k), DW'({rvalid1[k], rvalid0[k]}), '0);
      chk($sformatf("regceb dut%0d", k), DW'(regceb[k]), DW'(k == 0));
      chk($sformatf("rstb dut%0d", k), DW'(rstb[k]), '0);
    end
    @(negedge clka);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
  endtask

  // monitor: pops the expected queue whenever a response appears
  task automatic mon(input int k);
    logic [EW-1:0] e;
    int            n;
    n = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (rvalid0[k] || rvalid1[k]) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid dut%0d cyc%0d actual=%b%b required=00",
                 k, cyc, rvalid1[k], rvalid0[k]);
      end else begin
        if (k == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk($sformatf("rvalid_onehot dut%0d cyc%0d", k, cyc), DW'(rvalid0[k] & rvalid1[k]), '0);
        chk($sformatf("rsp_id dut%0d cyc%0d", k, cyc), DW'(rvalid1[k]), DW'(e[EW-1]));
        chk($sformatf("rsp_cycle dut%0d", k), DW'(cyc), DW'(e[EW-2:DW]));
        chk($sformatf("rdata dut%0d cyc%0d", k, cyc), rdata[k], e[DW-1:0]);
      end
    end else if (n > 0) begin
      e = (k == 0) ? exp_q0[0] : exp_q1[0];
      if (int'(e[EW-2:DW]) < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid dut%0d cyc%0d actual=none required=id%0d due%0d",
                 k, cyc, e[EW-1], e[EW-2:DW]);
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
      end
    end
  endtask

  always @(posedge clka) begin
    #1;
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    logic [AW-1:0] ra, rb, wa;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    do_reset();

    // requester 0 alone, addresses 1..4
    for (int i = 1; i <= 4; i++) drive(1'b1, AW'(i), 1'b0, '0, 1'b0, '0, '0);
    repeat (3) drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // both requesting for 6 cycles
    for (int i = 0; i < 6; i++)
      drive(1'b1, AW'($urandom_range(0, 63)), 1'b1, AW'($urandom_range(0, 63)), 1'b0, '0, '0);

    // same-edge write and read of address 5
    drive(1'b1, AW'(5), 1'b0, '0, 1'b1, AW'(5), 64'hAA);
    drive(1'b0, '0, 1'b1, AW'(5), 1'b0, '0, '0);

    // requester 1 alone at address 7
    drive(1'b0, '0, 1'b1, AW'(7), 1'b0, '0, '0);
    repeat (3) drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // reset one cycle after two issues; pointer restarts at requester 0
    drive(1'b1, AW'(10), 1'b0, '0, 1'b0, '0, '0);
    drive(1'b0, '0, 1'b1, AW'(11), 1'b0, '0, '0);
    do_reset();
    repeat (2) drive(1'b1, AW'(20), 1'b1, AW'(21), 1'b0, '0, '0);
    repeat (3) drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // random traffic over a small address window to force collisions
    for (int i = 0; i < 300; i++) begin
      ra = AW'($urandom_range(0, 15));
      rb = AW'($urandom_range(0, 15));
      wa = AW'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), rb,
            1'($urandom_range(0, 1)), wa, {$urandom, $urandom});
    end

    repeat (4) drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    chk("drain_q_lat2", DW'(exp_q0.size()), '0);
    chk("drain_q_lat1", DW'(exp_q1.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
